// File: rtl/rbe_tcdm_responder_if.sv
// Flattened MP-port 32-bit TCDM bus between the RBE wrapper (master) and a
// cluster-memory responder (slave).
interface rbe_tcdm_responder_if #(
    parameter int MP = 4
);
    logic [MP-1:0]       req;
    logic [MP-1:0]       gnt;
    logic [MP-1:0][31:0] add;
    logic [MP-1:0]       wen;
    logic [MP-1:0][3:0]  be;
    logic [MP-1:0][31:0] data;
    logic [MP-1:0][31:0] r_data;
    logic [MP-1:0]       r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );
endinterface

// File: rtl/rbe_tcdm_responder.sv
// TCDM slave: MP ports onto N_BANKS word-interleaved banks, round-robin per bank,
// 1-cycle read latency. Define RBE_TCDM_RESP_STALL_EN for LFSR-driven grant stalls.
module rbe_tcdm_responder #(
    parameter int MP         = 4,
    parameter int N_BANKS    = 8,
    parameter int BANK_WORDS = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rbe_tcdm_responder_if.slave  tcdm
);
    localparam int BIW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int RW  = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
    localparam int PW  = (MP > 1) ? $clog2(MP) : 1;

    logic [MP-1:0][BIW-1:0]     bank_idx;
    logic [MP-1:0][RW-1:0]      row_idx;
    logic [MP-1:0][1:0]         add_unused;
    logic [MP-1:0]              elig;
    logic [MP-1:0]              gnt;

    logic [N_BANKS-1:0]         win_vld;
    logic [N_BANKS-1:0][PW-1:0] win_port;
    logic [N_BANKS-1:0][PW-1:0] rr_q, rr_d;
    logic [N_BANKS-1:0][31:0]   bank_rdata;

    logic [MP-1:0]              r_valid_q, r_valid_d;
    logic [MP-1:0][BIW-1:0]     rsp_bank_q;
    logic [MP-1:0][31:0]        r_hold_q;
    logic [MP-1:0][31:0]        r_data;

    // Word-interleaved decode; bits above bank+row wrap, byte offset is dropped.
    for (genvar p = 0; p < MP; p++) begin : g_dec
        logic [29:0] word;
        assign word          = tcdm.add[p][31:2];
        assign bank_idx[p]   = BIW'(word % N_BANKS);
        assign row_idx[p]    = RW'((word / N_BANKS) % BANK_WORDS);
        assign add_unused[p] = tcdm.add[p][1:0];
    end

`ifdef RBE_TCDM_RESP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end

    // A stalled port is invisible to arbitration, so it never moves a pointer.
    for (genvar p = 0; p < MP; p++) begin : g_stall
        assign elig[p] = tcdm.req[p] & ~lfsr_q[p % 16];
    end
`else
    assign elig = tcdm.req;
`endif

    always_comb begin
        int idx;
        idx      = 0;
        win_vld  = '0;
        win_port = '0;
        rr_d     = rr_q;
        for (int b = 0; b < N_BANKS; b++) begin
            for (int k = 0; k < MP; k++) begin
                idx = int'(rr_q[b]) + k;
                if (idx >= MP) idx -= MP;
                if (!win_vld[b] && elig[idx] && bank_idx[idx] == BIW'(b)) begin
                    win_vld[b]  = 1'b1;
                    win_port[b] = PW'(idx);
                end
            end
            if (win_vld[b])
                rr_d[b] = (int'(win_port[b]) == MP - 1) ? '0 : win_port[b] + 1'b1;
        end
    end

    always_comb begin
        gnt = '0;
        for (int b = 0; b < N_BANKS; b++)
            if (win_vld[b]) gnt[win_port[b]] = 1'b1;
    end

    assign tcdm.gnt = gnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rr_q <= '0;
        else       rr_q <= rr_d;
    end

    // One access per bank per cycle; nonblocking update gives read-before-write.
    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic [31:0]   mem_q [BANK_WORDS];
        logic [31:0]   rdata_q;
        logic [PW-1:0] wp;
        logic [RW-1:0] row;
        logic          we, re;

        assign wp            = win_port[b];
        assign row           = row_idx[wp];
        assign we            = win_vld[b] & ~tcdm.wen[wp];
        assign re            = win_vld[b] &  tcdm.wen[wp];
        assign bank_rdata[b] = rdata_q;

        always_ff @(posedge clk_i) begin
            if (re) rdata_q <= mem_q[row];
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (tcdm.be[wp][i]) mem_q[row][i*8 +: 8] <= tcdm.data[wp][i*8 +: 8];
            end
        end
    end

    assign r_valid_d = gnt & tcdm.wen;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_q  <= '0;
            rsp_bank_q <= '0;
            r_hold_q   <= '0;
        end else begin
            r_valid_q <= r_valid_d;
            r_hold_q  <= r_data;
            for (int p = 0; p < MP; p++)
                if (r_valid_d[p]) rsp_bank_q[p] <= bank_idx[p];
        end
    end

    // Fresh bank data on a response cycle, otherwise the last value presented.
    always_comb begin
        r_data = r_hold_q;
        for (int p = 0; p < MP; p++)
            if (r_valid_q[p]) r_data[p] = bank_rdata[rsp_bank_q[p]];
    end

    assign tcdm.r_data  = r_data;
    assign tcdm.r_valid = r_valid_q;
endmodule

// File: tb/tb_rbe_tcdm_responder.sv
// Directed vector bench for rbe_tcdm_responder (MP=4, N_BANKS=8, BANK_WORDS=1024).
module tb_rbe_tcdm_responder;
    localparam int MP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rbe_tcdm_responder_if #(.MP(MP)) tcdm ();

    rbe_tcdm_responder #(.MP(MP), .N_BANKS(8), .BANK_WORDS(1024)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .tcdm  (tcdm)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]       req;
        logic [3:0]       wen;
        logic [3:0][31:0] add;
        logic [3:0][3:0]  be;
        logic [3:0][31:0] data;
        logic [3:0]       gnt;
        logic [3:0]       rvld;
        logic [3:0][31:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] wen,
                                input logic [127:0] add, input logic [15:0] be,
                                input logic [127:0] data, input logic [3:0] gnt,
                                input logic [3:0] rvld, input logic [127:0] rdata);
        vec_t v;
        v.req = req; v.wen = wen; v.add = add; v.be = be; v.data = data;
        v.gnt = gnt; v.rvld = rvld; v.rdata = rdata;
        return v;
    endfunction

    task automatic drive(input logic [3:0] req, input logic [3:0] wen, input logic [127:0] add,
                         input logic [15:0] be, input logic [127:0] data);
        tcdm.req  = req;
        tcdm.wen  = wen;
        tcdm.add  = add;
        tcdm.be   = be;
        tcdm.data = data;
    endtask

`ifdef RBE_TCDM_RESP_STALL_EN
    logic [15:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end
`endif

    vec_t tbl[$];

    initial begin
        drive(4'h0, 4'h0, '0, '0, '0);
        repeat (2) @(negedge clk);
        chk("rst gnt", {28'h0, tcdm.gnt}, 32'h0);
        chk("rst rvalid", {28'h0, tcdm.r_valid}, 32'h0);
        for (int p = 0; p < MP; p++) chk($sformatf("rst rdata%0d", p), tcdm.r_data[p], 32'h0);
        rst = 1'b0;

`ifndef RBE_TCDM_RESP_STALL_EN
        // Port lanes are packed {p3, p2, p1, p0}.
        tbl.push_back(mk(4'b0001, 4'b0000, {96'h0, 32'h0}, 16'h000F, {96'h0, 32'hDEADBEEF}, 4'b0001, 4'b0000, '0));
        tbl.push_back(mk(4'b0001, 4'b0001, {96'h0, 32'h0}, 16'h0000, '0, 4'b0001, 4'b0001, {96'h0, 32'hDEADBEEF}));
        tbl.push_back(mk(4'b1110, 4'b0000, {32'hC, 32'h8, 32'h4, 32'h0}, 16'hFFF0,
                         {32'h33333333, 32'h22222222, 32'h11111111, 32'h0}, 4'b1110, 4'b0000, '0));
        tbl.push_back(mk(4'b1111, 4'b1111, {32'hC, 32'h8, 32'h4, 32'h0}, 16'h0000, '0, 4'b1111, 4'b1111,
                         {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF}));
        tbl.push_back(mk(4'b1000, 4'b0000, {32'h20, 96'h0}, 16'hF000, {32'h20202020, 96'h0}, 4'b1000, 4'b0000, '0));
        tbl.push_back(mk(4'b0101, 4'b0101, {32'h0, 32'h20, 32'h0, 32'h20}, 16'h0, '0, 4'b0001, 4'b0001, {96'h0, 32'h20202020}));
        tbl.push_back(mk(4'b0101, 4'b0101, {32'h0, 32'h20, 32'h0, 32'h20}, 16'h0, '0, 4'b0100, 4'b0100, {32'h0, 32'h20202020, 64'h0}));
        tbl.push_back(mk(4'b0101, 4'b0101, {32'h0, 32'h20, 32'h0, 32'h20}, 16'h0, '0, 4'b0001, 4'b0001, {96'h0, 32'h20202020}));
        tbl.push_back(mk(4'b0010, 4'b0000, {64'h0, 32'h40, 32'h0}, 16'h00F0, {64'h0, 32'h11223344, 32'h0}, 4'b0010, 4'b0000, '0));
        tbl.push_back(mk(4'b0010, 4'b0000, {64'h0, 32'h40, 32'h0}, 16'h0050, {64'h0, 32'hAABBCCDD, 32'h0}, 4'b0010, 4'b0000, '0));
        tbl.push_back(mk(4'b0010, 4'b0010, {64'h0, 32'h40, 32'h0}, 16'h0, '0, 4'b0010, 4'b0010, {64'h0, 32'h11BB33DD, 32'h0}));
        tbl.push_back(mk(4'b0001, 4'b0000, {96'h0, 32'h0}, 16'h000F, {96'h0, 32'h5A5A5A5A}, 4'b0001, 4'b0000, '0));
        tbl.push_back(mk(4'b1000, 4'b1000, {32'h8000, 96'h0}, 16'h0, '0, 4'b1000, 4'b1000, {32'h5A5A5A5A, 96'h0}));
        tbl.push_back(mk(4'b0000, 4'b0000, '0, 16'h0, '0, 4'b0000, 4'b0000, '0));
        tbl.push_back(mk(4'b1010, 4'b1000, {32'h20, 32'h0, 32'h60, 32'h0}, 16'h00F0,
                         {64'h0, 32'h60606060, 32'h0}, 4'b0010, 4'b0000, '0));
        tbl.push_back(mk(4'b1000, 4'b1000, {32'h20, 96'h0}, 16'h0, '0, 4'b1000, 4'b1000, {32'h20202020, 96'h0}));
        tbl.push_back(mk(4'b0100, 4'b0100, {32'h0, 32'h60, 64'h0}, 16'h0, '0, 4'b0100, 4'b0100, {32'h0, 32'h60606060, 64'h0}));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].req, tbl[i].wen, tbl[i].add, tbl[i].be, tbl[i].data);
            #1 chk($sformatf("v%0d gnt", i), {28'h0, tcdm.gnt}, {28'h0, tbl[i].gnt});
            @(posedge clk);
            #1 chk($sformatf("v%0d rvalid", i), {28'h0, tcdm.r_valid}, {28'h0, tbl[i].rvld});
            for (int p = 0; p < MP; p++)
                if (tbl[i].rvld[p])
                    chk($sformatf("v%0d rdata%0d", i, p), tcdm.r_data[p], tbl[i].rdata[p]);
        end

        // Idle cycle: r_data holds the last response.
        @(negedge clk);
        drive(4'h0, 4'h0, '0, '0, '0);
        @(posedge clk);
        #1 chk("hold rvalid", {28'h0, tcdm.r_valid}, 32'h0);
        chk("hold rdata2", tcdm.r_data[2], 32'h60606060);

        // Read grant from port 2 to bank 0 (rr[0] -> 3), then reset squashes the response.
        @(negedge clk);
        drive(4'b0100, 4'b0100, '0, '0, '0);
        @(posedge clk);
        #1 chk("pre-rst rvalid", {28'h0, tcdm.r_valid}, 32'h4);
        rst = 1'b1;
        drive(4'h0, 4'h0, '0, '0, '0);
        #1 chk("squash rvalid", {28'h0, tcdm.r_valid}, 32'h0);
        chk("squash rdata2", tcdm.r_data[2], 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // rr[0] back at 0: port 0 beats port 3 on bank 0.
        @(negedge clk);
        drive(4'b1001, 4'b1001, {32'h20, 64'h0, 32'h0}, '0, '0);
        #1 chk("rr-rst gnt", {28'h0, tcdm.gnt}, 32'h1);
        @(posedge clk);
        #1 chk("rr-rst rvalid", {28'h0, tcdm.r_valid}, 32'h1);
        chk("rr-rst rdata0", tcdm.r_data[0], 32'h5A5A5A5A);
        @(negedge clk);
        drive(4'h0, 4'h0, '0, '0, '0);
`else
        // Constant reads to four distinct banks; only the LFSR can drop a grant.
        begin
            logic [3:0] exp_g;
            drive(4'b1111, 4'b1111, {32'hC, 32'h8, 32'h4, 32'h0}, '0, '0);
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                #1 exp_g = ~lfsr_m[3:0];
                chk($sformatf("stall%0d gnt", c), {28'h0, tcdm.gnt}, {28'h0, exp_g});
                @(posedge clk);
                #1 chk($sformatf("stall%0d rvalid", c), {28'h0, tcdm.r_valid}, {28'h0, exp_g});
            end
            drive(4'h0, 4'h0, '0, '0, '0);
        end
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
